// File: rtl/icache_pkg.sv
// Shared types, constants and address-split width helpers for the instruction cache.
package icache_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    REFILL
  } state_e;

  // Bits selecting a word within a line.
  function automatic int unsigned word_bits(int unsigned wpl);
    return 32'($clog2(wpl));
  endfunction

  // Bits selecting a cache line.
  function automatic int unsigned index_bits(int unsigned lines);
    return 32'($clog2(lines));
  endfunction

  // Remaining upper address bits stored as the tag.
  function automatic int unsigned tag_bits(int unsigned lines, int unsigned wpl);
    return XLEN - 2 - word_bits(wpl) - index_bits(lines);
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Line-refill request/burst channel between the instruction cache and backing memory.
interface icache_fetch_if;
  import icache_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/icache_line_store.sv
// Flop-based valid/tag/data arrays: combinational read, one word write, tag/valid write.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WPL   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [index_bits(LINES)-1:0]  rd_index,
  input  logic [word_bits(WPL)-1:0]     rd_word,
  output logic                          rd_valid,
  output logic [tag_bits(LINES,WPL)-1:0] rd_tag,
  output logic [XLEN-1:0]               rd_data,
  input  logic                          wr_en,
  input  logic [index_bits(LINES)-1:0]  wr_index,
  input  logic [word_bits(WPL)-1:0]     wr_word,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          tag_we,
  input  logic [tag_bits(LINES,WPL)-1:0] tag_wdata,
  input  logic                          valid_wdata,
  input  logic                          clear_all
);

  localparam int unsigned TB = tag_bits(LINES, WPL);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TB-1:0]    tag_q  [LINES];
  logic [TB-1:0]    tag_d  [LINES];
  logic [XLEN-1:0]  data_q [LINES][WPL];
  logic [XLEN-1:0]  data_d [LINES][WPL];

  // Read port straight from the flops so hits resolve in the same cycle.
  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

  // Next-state: global clear first, then the line being finished may set its own valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_all) begin
      valid_d = '0;
    end
    if (tag_we) begin
      valid_d[wr_index] = valid_wdata;
      tag_d[wr_index]   = tag_wdata;
    end
    if (wr_en) begin
      data_d[wr_index][wr_word] = wr_data;
    end
  end

  // Valid bits are the only array state that needs reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays hold whatever was last written.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache for the fetch stage: same-cycle hits, stall-and-refill on miss.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             fetch_req,
  input  logic             invalidate,
  output logic [XLEN-1:0]  instr_out,
  output logic             instr_valid,
  output logic             icache_stall,
  icache_fetch_if.master   mem
);

  localparam int unsigned WB    = word_bits(WORDS_PER_LINE);
  localparam int unsigned IB    = index_bits(LINES);
  localparam int unsigned TB    = tag_bits(LINES, WORDS_PER_LINE);
  localparam int unsigned OFF_W = WB + 2;

  state_e          state_q, state_d;
  logic [IB-1:0]   miss_index_q, miss_index_d;
  logic [TB-1:0]   miss_tag_q, miss_tag_d;
  logic [WB-1:0]   cnt_q, cnt_d;
  logic            inv_pending_q, inv_pending_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;

  logic [WB-1:0]   pc_word;
  logic [IB-1:0]   pc_index;
  logic [TB-1:0]   pc_tag;
  logic            rd_valid;
  logic [TB-1:0]   rd_tag;
  logic [XLEN-1:0] rd_data;
  logic            hit;
  logic            wr_en;
  logic            tag_we;
  logic            valid_wdata;
  logic            unused_byte_bits;

  // Address split; the byte offset never affects an aligned fetch.
  assign pc_word          = pc_in[2 +: WB];
  assign pc_index         = pc_in[OFF_W +: IB];
  assign pc_tag           = pc_in[OFF_W + IB +: TB];
  assign unused_byte_bits = ^pc_in[1:0];

  icache_line_store #(
    .LINES (LINES),
    .WPL   (WORDS_PER_LINE)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .rd_index    (pc_index),
    .rd_word     (pc_word),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_index    (miss_index_q),
    .wr_word     (cnt_q),
    .wr_data     (mem.mem_rdata),
    .tag_we      (tag_we),
    .tag_wdata   (miss_tag_q),
    .valid_wdata (valid_wdata),
    .clear_all   (invalidate)
  );

  // Same-cycle hit/stall; held quiet while reset is asserted.
  assign hit          = rd_valid && (rd_tag == pc_tag);
  assign instr_valid  = !reset && (state_q == IDLE) && fetch_req && hit;
  assign icache_stall = !reset && ((state_q != IDLE) || (fetch_req && !hit));
  assign instr_out    = instr_valid ? rd_data : NOP_INSTR;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  // Miss handling: latch line base, hold the request until accepted, then count beats in.
  always_comb begin
    state_d       = state_q;
    miss_index_d  = miss_index_q;
    miss_tag_d    = miss_tag_q;
    cnt_d         = cnt_q;
    inv_pending_d = inv_pending_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    wr_en         = 1'b0;
    tag_we        = 1'b0;
    valid_wdata   = 1'b0;

    unique case (state_q)
      IDLE: begin
        inv_pending_d = 1'b0;
        if (fetch_req && !hit) begin
          miss_index_d = pc_index;
          miss_tag_d   = pc_tag;
          mem_addr_d   = {pc_tag, pc_index, OFF_W'(0)};
          mem_req_d    = 1'b1;
          cnt_d        = '0;
          state_d      = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (invalidate) begin
          inv_pending_d = 1'b1;
        end
        if (mem.mem_ready) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        if (invalidate) begin
          inv_pending_d = 1'b1;
        end
        if (mem.mem_rvalid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + WB'(1);
          if (cnt_q == WB'(WORDS_PER_LINE - 1)) begin
            tag_we        = 1'b1;
            valid_wdata   = !(inv_pending_q || invalidate);
            cnt_d         = '0;
            inv_pending_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      miss_index_q  <= '0;
      miss_tag_q    <= '0;
      cnt_q         <= '0;
      inv_pending_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      miss_index_q  <= miss_index_d;
      miss_tag_q    <= miss_tag_d;
      cnt_q         <= cnt_d;
      inv_pending_q <= inv_pending_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: hit table plus hand-written miss/refill/invalidate/reset sequences.
module tb_icache_fetch;

  localparam int unsigned WPL = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        fetch_req;
  logic        invalidate;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        icache_stall;

  int n_checks;
  int n_fail;

  icache_fetch_if bus ();

  icache_fetch #(
    .LINES          (16),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .fetch_req    (fetch_req),
    .invalidate   (invalidate),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .icache_stall (icache_stall),
    .mem          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fetch;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the miss-detect cycle; returns in the first IDLE cycle after the last beat.
  task automatic refill(input logic [31:0] exp_addr, input logic [31:0] dbase,
                        input int ready_delay, input int gap, input int inv_beat);
    tick();
    for (int i = 0; i < ready_delay; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      chk("wait_mem_req", 32'(bus.mem_req), 32'd1);
      chk("wait_mem_addr", bus.mem_addr, exp_addr);
      chk("wait_stall", 32'(icache_stall), 32'd1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("req_mem_req", 32'(bus.mem_req), 32'd1);
    chk("req_mem_addr", bus.mem_addr, exp_addr);
    chk("req_stall", 32'(icache_stall), 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    for (int b = 0; b < int'(WPL); b++) begin
      for (int g = 0; g < gap; g++) begin
        bus.mem_rvalid = 1'b0;
        invalidate     = 1'b0;
        #1;
        chk("gap_stall", 32'(icache_stall), 32'd1);
        chk("gap_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = dbase + 32'(b);
      invalidate     = (b == inv_beat);
      #1;
      chk("beat_stall", 32'(icache_stall), 32'd1);
      chk("beat_mem_req", 32'(bus.mem_req), 32'd0);
      chk("beat_instr_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    invalidate     = 1'b0;
  endtask

  // Present a fetch and check for a same-cycle hit.
  task automatic expect_hit(input string name, input logic [31:0] pc, input logic [31:0] data);
    pc_in     = pc;
    fetch_req = 1'b1;
    #1;
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk({name, "_instr"}, instr_out, data);
    chk({name, "_stall"}, 32'(icache_stall), 32'd0);
    chk({name, "_mem_req"}, 32'(bus.mem_req), 32'd0);
  endtask

  // Present a fetch and check it is reported as a miss.
  task automatic expect_miss(input string name, input logic [31:0] pc);
    pc_in     = pc;
    fetch_req = 1'b1;
    #1;
    chk({name, "_valid"}, 32'(instr_valid), 32'd0);
    chk({name, "_instr"}, instr_out, NOP);
    chk({name, "_stall"}, 32'(icache_stall), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{pc: 32'h104, fetch: 1'b1, exp_valid: 1'b1, exp_instr: 32'hA000_0001, exp_stall: 1'b0};
    vecs[1] = '{pc: 32'h108, fetch: 1'b1, exp_valid: 1'b1, exp_instr: 32'hA000_0002, exp_stall: 1'b0};
    vecs[2] = '{pc: 32'h10C, fetch: 1'b1, exp_valid: 1'b1, exp_instr: 32'hA000_0003, exp_stall: 1'b0};
    vecs[3] = '{pc: 32'h106, fetch: 1'b1, exp_valid: 1'b1, exp_instr: 32'hA000_0001, exp_stall: 1'b0};
    vecs[4] = '{pc: 32'h100, fetch: 1'b0, exp_valid: 1'b0, exp_instr: NOP,           exp_stall: 1'b0};
    vecs[5] = '{pc: 32'h700, fetch: 1'b0, exp_valid: 1'b0, exp_instr: NOP,           exp_stall: 1'b0};
    vecs[6] = '{pc: 32'h100, fetch: 1'b1, exp_valid: 1'b1, exp_instr: 32'hA000_0000, exp_stall: 1'b0};

    reset          = 1'b1;
    pc_in          = '0;
    fetch_req      = 1'b0;
    invalidate     = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_stall", 32'(icache_stall), 32'd0);
    chk("rst_instr_out", instr_out, NOP);
    tick();

    // First miss on 0x100, default back-to-back timing.
    expect_miss("miss100", 32'h100);
    refill(32'h100, 32'hA000_0000, 0, 0, -1);
    expect_hit("fill100", 32'h100, 32'hA000_0000);
    tick();

    // Same-cycle hits and idle fetches from the table.
    for (int i = 0; i < 7; i++) begin
      pc_in     = vecs[i].pc;
      fetch_req = vecs[i].fetch;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_instr", i), instr_out, vecs[i].exp_instr);
      chk($sformatf("vec%0d_stall", i), 32'(icache_stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_mem_req", i), 32'(bus.mem_req), 32'd0);
      tick();
    end

    // Conflict miss: 0x500 shares the index with 0x100.
    expect_miss("miss500", 32'h500);
    refill(32'h500, 32'hB000_0000, 0, 0, -1);
    expect_hit("fill500", 32'h500, 32'hB000_0000);
    tick();
    expect_hit("hit50c", 32'h50C, 32'hB000_0003);
    tick();

    // Evicted line misses again; slow acceptance and gapped beats.
    expect_miss("remiss100", 32'h100);
    refill(32'h100, 32'hC000_0000, 5, 2, -1);
    expect_hit("slow100", 32'h100, 32'hC000_0000);
    tick();
    expect_hit("slow108", 32'h108, 32'hC000_0002);
    tick();

    // Invalidate during refill: line completes but stays invalid.
    expect_miss("miss240", 32'h240);
    refill(32'h240, 32'hD000_0000, 0, 0, 1);
    expect_miss("inv_refill240", 32'h240);
    refill(32'h240, 32'hD100_0000, 0, 0, -1);
    expect_hit("fill240", 32'h240, 32'hD100_0000);
    tick();

    // Invalidate in IDLE: same-cycle lookup still hits, next fetch misses.
    pc_in      = 32'h244;
    fetch_req  = 1'b1;
    invalidate = 1'b1;
    #1;
    chk("inv_idle_valid", 32'(instr_valid), 32'd1);
    chk("inv_idle_instr", instr_out, 32'hD100_0001);
    tick();
    invalidate = 1'b0;
    expect_miss("after_inv244", 32'h244);
    refill(32'h240, 32'hE000_0000, 0, 0, -1);
    expect_hit("fill244", 32'h244, 32'hE000_0001);
    tick();

    // Reset in the middle of a refill.
    expect_miss("miss300", 32'h300);
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    fetch_req      = 1'b0;
    reset          = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(icache_stall), 32'd0);
    chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("stray_stall", 32'(icache_stall), 32'd0);
    chk("stray_mem_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    expect_miss("postrst240", 32'h240);
    refill(32'h240, 32'hF000_0000, 0, 0, -1);
    expect_hit("fill_post", 32'h24C, 32'hF000_0003);
    tick();

    fetch_req = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
